// File: rtl/task1_s_init.sv
`default_nettype none
// ============================================================================
// Module      : task1_s_init (with local RAM s_ram)
// Description : ARC4 cracking lab, stage 1. After reset, fills the 256x8
//               on-chip S RAM with the identity permutation S[i] = i, writing
//               one byte per clock, then parks in DONE and lights LEDR[0].
//
// Ports       : CLOCK_50    - 50 MHz clock, all logic on its rising edge
//               KEY[3]      - asynchronous active-low reset
//               KEY[2:0]    - unused
//               SW[9:0]     - unused
//               HEX0..HEX5  - seven-segment displays, active-low segments
//               LEDR[9:0]   - LEDR[0] = init done, LEDR[9:1] = 0
//
// Options     : TASK1_HEX_STATUS_EN - when defined, HEX1:HEX0 show the fill
//               counter in hex and HEX2 shows "d" in DONE. When undefined all
//               HEX outputs are constant blank. S contents, FSM timing and
//               LEDR are identical in both builds.
//
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// s_ram: single-port synchronous 256x8 RAM. The array is named mem so that
// the contents can be inspected hierarchically as <inst>.mem[idx].
// ----------------------------------------------------------------------------
module s_ram (
    input  logic       clk,
    input  logic [7:0] address,
    input  logic [7:0] data,
    input  logic       wren,
    output logic [7:0] q
);

    logic [7:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

module task1_s_init (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    localparam logic [6:0] c_HEX_BLANK = 7'b1111111;
    localparam logic [7:0] c_LAST_IDX  = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic       rst_n;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_i;
    logic [7:0] w_i_nxt;
    logic       r_done_led;

    logic       w_wren;
    logic [7:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] w_q;

    assign rst_n = KEY[3];

    // Inputs with no function in this stage; folded into one sink signal.
    logic w_unused;
    assign w_unused = ^{KEY[2:0], SW, w_q};

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_i        <= 8'd0;
            r_done_led <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_i        <= w_i_nxt;
            // Registered so the LED rises one edge after entry into DONE,
            // i.e. one edge after the final write.
            r_done_led <= (r_state == ST_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Next-state and RAM port drive
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_wren      = 1'b0;
        w_addr      = 8'd0;
        w_data      = 8'd0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FILL;
                w_i_nxt     = 8'd0;
            end
            ST_FILL: begin
                w_wren = 1'b1;
                w_addr = r_i;
                w_data = r_i;
                // Final byte: leave i at FF rather than wrapping, so the
                // counter never re-addresses location 0.
                if (r_i == c_LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_i_nxt = r_i + 8'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_i_nxt     = 8'd0;
            end
        endcase
    end

    s_ram s (
        .clk     (CLOCK_50),
        .address (w_addr),
        .data    (w_data),
        .wren    (w_wren),
        .q       (w_q)
    );

    assign LEDR = {9'd0, r_done_led};

    // ------------------------------------------------------------------
    // Seven-segment status
    // ------------------------------------------------------------------
`ifdef TASK1_HEX_STATUS_EN
    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        logic [6:0] seg;
        seg = c_HEX_BLANK;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = c_HEX_BLANK;
        endcase
        return seg;
    endfunction

    // Blank while idle (including under reset); counter shown otherwise.
    assign HEX0 = (r_state == ST_IDLE) ? c_HEX_BLANK : f_glyph(r_i[3:0]);
    assign HEX1 = (r_state == ST_IDLE) ? c_HEX_BLANK : f_glyph(r_i[7:4]);
    assign HEX2 = (r_state == ST_DONE) ? 7'b0100001  : c_HEX_BLANK;
    assign HEX3 = c_HEX_BLANK;
    assign HEX4 = c_HEX_BLANK;
    assign HEX5 = c_HEX_BLANK;
`else
    assign HEX0 = c_HEX_BLANK;
    assign HEX1 = c_HEX_BLANK;
    assign HEX2 = c_HEX_BLANK;
    assign HEX3 = c_HEX_BLANK;
    assign HEX4 = c_HEX_BLANK;
    assign HEX5 = c_HEX_BLANK;
`endif

endmodule

`default_nettype wire

// File: tb/tb_task1_s_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_task1_s_init
// Description : Self-checking bench for task1_s_init. The reference model is
//               the write schedule implied by the fill rules: after release,
//               edge k writes S[k-2] = k-2 for 2 <= k <= 257, nothing else is
//               ever written, LEDR[0] is high from edge 258 on, and the final
//               S image is the identity permutation. SW and KEY[2:0] are
//               randomly toggled during some runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_task1_s_init;

    logic       clk;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int  n_vec;
    int  n_err;
    bit  noise_en;

    logic [7:0] ref_s [0:255];

    task1_s_init dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

`ifdef TASK1_HEX_STATUS_EN
    function automatic logic [6:0] glyph(input int v);
        logic [6:0] t [0:15];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v & 15];
    endfunction
`endif

    task automatic drive_noise();
        if (noise_en) begin
            SW       = 10'($urandom);
            KEY[2:0] = 3'($urandom);
        end
    endtask

    // Assert reset at a falling edge, hold for 'hold' cycles while checking
    // the reset outputs, then release just after a falling edge.
    task automatic apply_reset(input int hold);
        @(negedge clk);
        KEY[3] = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            drive_noise();
            #1;
            n_vec++;
            if (LEDR !== 10'd0 || dut.s.wren !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: LEDR=%h wren=%b, required LEDR=000 wren=0",
                         LEDR, dut.s.wren);
            end
            n_vec++;
            if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'h7F}}) begin
                n_err++;
                $display("FAIL reset_hex: HEX5..0=%h %h %h %h %h %h, required all 7f",
                         HEX5, HEX4, HEX3, HEX2, HEX1, HEX0);
            end
        end
        KEY[3] = 1'b1;
    endtask

    // Walk edges 1..last after release, comparing the RAM port activity and
    // outputs against the write schedule, then compare the S image.
    task automatic run_and_check_fill(input int hold, input int extra);
        int  last;
        bit  exp_wr;
        logic [7:0] exp_addr;
        int  wr_err;
        int  led_err;
        int  hex_err;
        wr_err  = 0;
        led_err = 0;
        hex_err = 0;
        last    = 260 + extra;
        apply_reset(hold);
        for (int k = 1; k <= last; k++) begin
            drive_noise();
            #1;
            exp_wr   = (k >= 2 && k <= 257);
            exp_addr = exp_wr ? 8'(k - 2) : 8'd0;
            n_vec++;
            if (dut.s.wren !== exp_wr || dut.s.address !== exp_addr ||
                (exp_wr && dut.s.data !== exp_addr)) begin
                n_err++;
                if (wr_err++ < 5)
                    $display("FAIL write_sched edge %0d: wren=%b addr=%0d data=%0d, required wren=%b addr=%0d data=%0d",
                             k, dut.s.wren, dut.s.address, dut.s.data, exp_wr, exp_addr, exp_addr);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (LEDR !== {9'd0, (k >= 258)}) begin
                n_err++;
                if (led_err++ < 5)
                    $display("FAIL ledr edge %0d: LEDR=%h, required %h", k, LEDR, {9'd0, (k >= 258)});
            end
            n_vec++;
`ifdef TASK1_HEX_STATUS_EN
            if (HEX0 !== glyph((k >= 257) ? 255 : k - 1) ||
                HEX1 !== glyph(((k >= 257) ? 255 : k - 1) >> 4) ||
                HEX2 !== ((k >= 257) ? 7'h21 : 7'h7F) ||
                {HEX5, HEX4, HEX3} !== {3{7'h7F}}) begin
`else
            if ({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} !== {6{7'h7F}}) begin
`endif
                n_err++;
                if (hex_err++ < 5)
                    $display("FAIL hex edge %0d: HEX2..0=%h %h %h HEX5..3=%h %h %h",
                             k, HEX2, HEX1, HEX0, HEX5, HEX4, HEX3);
            end
            @(negedge clk);
        end
        for (int j = 0; j < 256; j++) begin
            n_vec++;
            if (dut.s.mem[j] !== ref_s[j]) begin
                n_err++;
                $display("FAIL s_image[%0d]: got %0d, required %0d", j, dut.s.mem[j], ref_s[j]);
            end
        end
    endtask

    task automatic test_reset();
        noise_en = 1'b0;
        apply_reset(5);
        KEY[3] = 1'b0;
        #1;
        n_vec++;
        if (dut.s.address !== 8'd0) begin
            n_err++;
            $display("FAIL reset_addr: addr=%0d, required 0", dut.s.address);
        end
    endtask

    task automatic test_fill();
        noise_en = 1'b0;
        run_and_check_fill(5, 1140);
    endtask

    task automatic test_noise_inputs();
        noise_en = 1'b1;
        run_and_check_fill(int'($urandom_range(3, 9)), int'($urandom_range(0, 20)));
    endtask

    task automatic test_midfill_reset();
        int stop_at;
        noise_en = 1'b1;
        stop_at  = 100 + int'($urandom_range(0, 60));
        apply_reset(int'($urandom_range(2, 6)));
        // Edge 1 enters FILL; then stop_at more writing cycles.
        repeat (1 + stop_at) @(posedge clk);
        @(negedge clk);
        KEY[3] = 1'b0;
        #1;
        n_vec++;
        if (dut.s.wren !== 1'b0 || dut.s.address !== 8'd0 || LEDR !== 10'd0) begin
            n_err++;
            $display("FAIL midfill_reset: wren=%b addr=%0d LEDR=%h, required wren=0 addr=0 LEDR=000",
                     dut.s.wren, dut.s.address, LEDR);
        end
        run_and_check_fill(int'($urandom_range(2, 6)), 40);
    endtask

    task automatic test_back_to_back();
        noise_en = 1'b1;
        run_and_check_fill(1, 0);
        run_and_check_fill(int'($urandom_range(1, 4)), 0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        noise_en = 1'b0;
        KEY      = 4'b1111;
        SW       = 10'd0;
        for (int j = 0; j < 256; j++) ref_s[j] = 8'(j);

        test_reset();
        test_fill();
        test_noise_inputs();
        test_midfill_reset();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
